// File: rtl/lcd_arbiter_if.sv
// Bundle of the requester handshakes and the Avalon-MM write port toward the LCD controller.
// The master modport is the arbiter's view; the slave modport is the requesters plus LCD slave.
interface lcd_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0][8:0]  req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;

  logic                   address;
  logic                   chipselect;
  logic                   byteenable;
  logic                   read;
  logic                   write;
  logic [7:0]             writedata;
  logic                   waitrequest;

  modport master (
    input  req_valid, req_data, req_last, waitrequest,
    output req_ready, address, chipselect, byteenable, read, write, writedata
  );

  modport slave (
    output req_valid, req_data, req_last, waitrequest,
    input  req_ready, address, chipselect, byteenable, read, write, writedata
  );
endinterface

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter that serialises multi-beat LCD messages from N_REQ requesters onto
// one Avalon-MM write port. A requester keeps the bus locked until its last beat or until
// it stalls for HOLD_TIMEOUT cycles.
//
// state | meaning
// IDLE  | no owner; round-robin pick among valid requesters, accept one beat
// WRITE | captured beat driven on the bus until waitrequest drops
// HOLD  | owner keeps the lock, waiting for its next beat or the stall timeout
module lcd_arbiter #(
  parameter int N_REQ        = 3,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  lcd_arbiter_if.master     bus,
  output logic [2:0]        grant_id,
  output logic              busy
);

  localparam int IW     = $clog2(N_REQ);
  localparam int LAST_I = N_REQ - 1;
  localparam logic [IW:0]   NREQ_W    = N_REQ[IW:0];
  localparam logic [IW-1:0] LAST_RST  = LAST_I[IW-1:0];
  localparam logic [15:0]   TIMEOUT16 = HOLD_TIMEOUT[15:0];

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t            state;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     last_owner;
  logic [15:0]       stall_cnt;
  logic              cap_last;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW:0]       cand;
  logic [N_REQ-1:0]  ready_v;
  logic              accept;
  logic [IW-1:0]     cap_idx;

  // Round-robin search starting one past the previous owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_owner} + i[IW:0];
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!win_found && bus.req_valid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // Ready goes to the round-robin winner when idle, only to the owner while locked.
  always_comb begin
    ready_v = '0;
    if (state == IDLE && win_found) ready_v[win_idx] = 1'b1;
    else if (state == HOLD)         ready_v[owner]   = 1'b1;
  end

  // Ready is forced low while reset is held so every output is quiet during reset.
  assign bus.req_ready  = reset ? ready_v : '0;
  assign bus.byteenable = 1'b1;
  assign bus.read       = 1'b0;

  assign accept  = (state == IDLE && win_found) || (state == HOLD && bus.req_valid[owner]);
  assign cap_idx = (state == HOLD) ? owner : win_idx;

  // Arbitration FSM; the bus outputs are the captured beat, registered on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      owner          <= '0;
      last_owner     <= LAST_RST;
      stall_cnt      <= '0;
      cap_last       <= 1'b0;
      bus.address    <= 1'b0;
      bus.writedata  <= 8'h00;
      bus.chipselect <= 1'b0;
      bus.write      <= 1'b0;
      grant_id       <= 3'd0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            bus.address    <= bus.req_data[cap_idx][8];
            bus.writedata  <= bus.req_data[cap_idx][7:0];
            cap_last       <= bus.req_last[cap_idx];
            owner          <= cap_idx;
            grant_id       <= 3'(cap_idx);
            busy           <= 1'b1;
            bus.chipselect <= 1'b1;
            bus.write      <= 1'b1;
            stall_cnt      <= '0;
            state          <= WRITE;
          end else if (state == HOLD) begin
            if (stall_cnt + 16'd1 == TIMEOUT16) begin
              last_owner <= owner;
              grant_id   <= 3'd0;
              busy       <= 1'b0;
              stall_cnt  <= '0;
              state      <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end
        end
        WRITE: begin
          if (!bus.waitrequest) begin
            bus.chipselect <= 1'b0;
            bus.write      <= 1'b0;
            bus.address    <= 1'b0;
            bus.writedata  <= 8'h00;
            stall_cnt      <= '0;
            if (cap_last) begin
              last_owner <= owner;
              grant_id   <= 3'd0;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= HOLD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_arbiter.sv
// Bench for lcd_arbiter: per-requester beat queues drive the handshakes, expected bus beats
// (owner id, address, data) are queued per scenario and popped as writes complete.
module tb_lcd_arbiter;
  localparam int N = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] grant_id;
  logic       busy;

  lcd_arbiter_if #(.N_REQ(N)) bus ();

  lcd_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    logic       last;
    int         gap;
  } beat_t;

  beat_t       src_q[N][$];
  int          gap_left[N];
  logic [11:0] sb_q[$];

  int n_checks    = 0;
  int n_fail      = 0;
  int writes_done = 0;
  int stall_left  = 0;

  logic         s_write, s_busy;
  logic [2:0]   s_grant;
  logic         s_addr;
  logic [7:0]   s_wdata;
  logic [N-1:0] s_ready, s_valid;

  task automatic push_beat(int r, logic [8:0] d, logic l, int gap);
    beat_t b;
    b.data = d; b.last = l; b.gap = gap;
    if (src_q[r].size() == 0) gap_left[r] = gap;
    src_q[r].push_back(b);
  endtask

  task automatic expect_beat(int id, logic [8:0] d);
    sb_q.push_back({3'(id), d});
  endtask

  task automatic clear_all();
    for (int r = 0; r < N; r++) begin
      src_q[r].delete();
      gap_left[r] = 0;
    end
    sb_q.delete();
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.req_last    = '0;
    bus.waitrequest = 1'b0;
    stall_left      = 0;
    writes_done     = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: drive sources and waitrequest on the falling edge, sample and score the bus,
  // then retire any beat handed over on the rising edge.
  task automatic step();
    logic [11:0] got, exp_v;
    @(negedge clk);
    if (bus.write && stall_left > 0) begin
      bus.waitrequest = 1'b1;
      stall_left--;
    end else begin
      bus.waitrequest = 1'b0;
    end
    for (int r = 0; r < N; r++) begin
      if (src_q[r].size() > 0 && gap_left[r] == 0) begin
        bus.req_valid[r] = 1'b1;
        bus.req_data[r]  = src_q[r][0].data;
        bus.req_last[r]  = src_q[r][0].last;
      end else begin
        bus.req_valid[r] = 1'b0;
        bus.req_data[r]  = '0;
        bus.req_last[r]  = 1'b0;
        if (gap_left[r] > 0) gap_left[r]--;
      end
    end
    #1;
    s_write = bus.write;  s_busy  = busy;      s_grant = grant_id;
    s_addr  = bus.address; s_wdata = bus.writedata;
    s_ready = bus.req_ready; s_valid = bus.req_valid;
    if (bus.write && !bus.waitrequest) begin
      got = {grant_id, bus.address, bus.writedata};
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_beat: unexpected write id/addr/data=%h, nothing expected", got);
      end else begin
        exp_v = sb_q.pop_front();
        if (got !== exp_v || bus.chipselect !== 1'b1) begin
          n_fail++;
          $display("FAIL bus_beat: got id/addr/data=%h cs=%b, expected %h cs=1",
                   got, bus.chipselect, exp_v);
        end
      end
      writes_done++;
    end
    @(posedge clk);
    for (int r = 0; r < N; r++) begin
      if (s_valid[r] && s_ready[r]) begin
        void'(src_q[r].pop_front());
        if (src_q[r].size() > 0) gap_left[r] = src_q[r][0].gap;
      end
    end
  endtask

  task automatic check_drained(string name, int exp_writes);
    n_checks++;
    if (sb_q.size() != 0 || writes_done != exp_writes) begin
      n_fail++;
      $display("FAIL %s_drain: writes=%0d pending=%0d, expected writes=%0d pending=0",
               name, writes_done, sb_q.size(), exp_writes);
    end
  endtask

  task automatic test_reset();
    clear_all();
    bus.req_valid = '1;
    bus.req_last  = '1;
    #2 reset = 1'b0;
    #3;
    n_checks++;
    if ({bus.write, bus.chipselect, bus.read, bus.address, bus.writedata} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_bus: w/cs/rd/addr/data=%b%b%b%b %h, expected all 0",
               bus.write, bus.chipselect, bus.read, bus.address, bus.writedata);
    end
    n_checks++;
    if (bus.byteenable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_byteenable: got %b expected 1", bus.byteenable);
    end
    n_checks++;
    if ({busy, grant_id} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b grant=%0d expected 0/0", busy, grant_id);
    end
    n_checks++;
    if (bus.req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 000", bus.req_ready);
    end
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    apply_reset();
    push_beat(0, 9'h001, 1'b1, 0);
    expect_beat(0, 9'h001);
    repeat (2) begin step(); busy_cnt += int'(s_busy); end
    n_checks++;
    if (writes_done != 1) begin
      n_fail++;
      $display("FAIL single_latency: writes after 2 cycles=%0d expected 1", writes_done);
    end
    repeat (6) begin step(); busy_cnt += int'(s_busy); end
    n_checks++;
    if (busy_cnt != 1) begin
      n_fail++;
      $display("FAIL single_busy: busy cycles=%0d expected 1", busy_cnt);
    end
    check_drained("single", 1);
  endtask

  task automatic test_alternate();
    int bad_ready = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      push_beat(0, 9'h0A0 + 9'(i), 1'b1, 0);
      push_beat(1, 9'h1B0 + 9'(i), 1'b1, 0);
      expect_beat(0, 9'h0A0 + 9'(i));
      expect_beat(1, 9'h1B0 + 9'(i));
    end
    repeat (12) begin
      step();
      if (!s_busy && s_valid != '0 && $countones(s_ready) != 1) bad_ready++;
    end
    n_checks++;
    if (writes_done != 6) begin
      n_fail++;
      $display("FAIL alternate_rate: writes after 12 cycles=%0d expected 6", writes_done);
    end
    n_checks++;
    if (bad_ready != 0) begin
      n_fail++;
      $display("FAIL alternate_onehot: idle cycles without one-hot ready=%0d expected 0", bad_ready);
    end
    repeat (4) step();
    check_drained("alternate", 6);
  endtask

  task automatic test_locked();
    int leak = 0;
    apply_reset();
    push_beat(0, 9'h0F0, 1'b1, 0);
    push_beat(0, 9'h0F1, 1'b1, 0);
    push_beat(1, 9'h144, 1'b0, 0);
    push_beat(1, 9'h169, 1'b0, 0);
    push_beat(1, 9'h172, 1'b1, 0);
    expect_beat(0, 9'h0F0);
    expect_beat(1, 9'h144);
    expect_beat(1, 9'h169);
    expect_beat(1, 9'h172);
    expect_beat(0, 9'h0F1);
    repeat (20) begin
      step();
      if (s_busy && s_grant == 3'd1 && s_ready[0]) leak++;
    end
    n_checks++;
    if (leak != 0) begin
      n_fail++;
      $display("FAIL locked_leak: non-owner ready cycles=%0d expected 0", leak);
    end
    check_drained("locked", 5);
  endtask

  task automatic test_wait();
    int wr0 = 0, unstable = 0;
    apply_reset();
    stall_left = 5;
    push_beat(0, 9'h055, 1'b1, 0);
    push_beat(1, 9'h166, 1'b1, 0);
    expect_beat(0, 9'h055);
    expect_beat(1, 9'h166);
    repeat (16) begin
      step();
      if (s_write && s_grant == 3'd0) begin
        wr0++;
        if ({s_addr, s_wdata} !== 9'h055) unstable++;
      end
    end
    n_checks++;
    if (wr0 != 6) begin
      n_fail++;
      $display("FAIL wait_len: write cycles=%0d expected 6", wr0);
    end
    n_checks++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL wait_stable: changed cycles=%0d expected 0", unstable);
    end
    check_drained("wait", 2);
  endtask

  task automatic test_stall_clear();
    apply_reset();
    push_beat(0, 9'h011, 1'b0, 0);
    push_beat(0, 9'h012, 1'b0, 4);
    push_beat(0, 9'h013, 1'b1, 4);
    push_beat(1, 9'h1EE, 1'b1, 0);
    expect_beat(0, 9'h011);
    expect_beat(0, 9'h012);
    expect_beat(0, 9'h013);
    expect_beat(1, 9'h1EE);
    repeat (30) step();
    check_drained("stall_clear", 4);
  endtask

  task automatic test_timeout();
    int hold_cnt = 0, idle_cnt = 0, bad_ready = 0;
    apply_reset();
    push_beat(0, 9'h011, 1'b0, 0);
    push_beat(2, 9'h222, 1'b1, 0);
    expect_beat(0, 9'h011);
    expect_beat(2, 9'h222);
    repeat (20) begin
      step();
      if (writes_done == 1) begin
        if (s_busy && !s_write) begin
          hold_cnt++;
          if (s_ready !== 3'b001 || s_grant !== 3'd0) bad_ready++;
        end
        if (!s_busy) begin
          idle_cnt++;
          if (s_ready !== 3'b100) bad_ready++;
        end
      end
    end
    n_checks++;
    if (hold_cnt != 4) begin
      n_fail++;
      $display("FAIL timeout_hold: hold cycles=%0d expected 4", hold_cnt);
    end
    n_checks++;
    if (idle_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_regrant: idle cycles before req2=%0d expected 1", idle_cnt);
    end
    n_checks++;
    if (bad_ready != 0) begin
      n_fail++;
      $display("FAIL timeout_ready: wrong ready/grant cycles=%0d expected 0", bad_ready);
    end
    check_drained("timeout", 2);
  endtask

  task automatic test_reset_mid_write();
    logic found = 1'b0;
    apply_reset();
    stall_left = 1000;
    push_beat(1, 9'h1AB, 1'b1, 0);
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_write) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midreset_start: write never seen, expected within 10 cycles");
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.write, bus.chipselect, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_drop: write/cs/busy=%b%b%b expected 000",
               bus.write, bus.chipselect, busy);
    end
    @(negedge clk);
    clear_all();
    reset = 1'b1;
    push_beat(0, 9'h0C3, 1'b1, 0);
    push_beat(1, 9'h1AB, 1'b1, 0);
    expect_beat(0, 9'h0C3);
    expect_beat(1, 9'h1AB);
    repeat (10) step();
    check_drained("midreset", 2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_locked();
    test_wait();
    test_stall_clear();
    test_timeout();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, giving the number of requesters (range 2..8).
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 255, giving the idle cycles a locked owner may stall before it is released (range 1..65535).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port req_valid  in  N_REQ  per-requester beat valid.
REQ-006 SHALL have port req_data  in  N_REQ x 9  per-requester beat: bit 8 = LCD address (0 = instruction, 1 = data), bits 7:0 = byte.
REQ-007 SHALL have port req_last  in  N_REQ  marks the final beat of a message; ends that requester's lock.
REQ-008 SHALL have port req_ready  out  N_REQ  per-requester accept; a beat transfers on a rising edge where valid and ready are both 1.
REQ-009 SHALL have Avalon-MM master ports toward the LCD controller slave: address out 1, chipselect out 1, byteenable out 1, read out 1, write out 1, writedata out 8, waitrequest in 1.
REQ-010 SHALL have port grant_id  out  3  index of the current owner (0 when no owner).
REQ-011 SHALL have port busy  out  1  1 whenever an owner holds the lock.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE and HOLD.
REQ-013 IDLE: when any req_valid is 1, the SHALL be exactly one req_ready asserted (combinationally), for the winner chosen round-robin, with search starting at last_owner+1 modulo N_REQ.
REQ-014 IDLE: on the accepting edge, the SHALL capture req_data[winner] and req_last[winner], set owner = winner, and go to WRITE; with no valid requests it SHALL remain in IDLE.
REQ-015 WRITE: chipselect = write = 1; address = captured bit 8; writedata = captured bits 7:0; all req_ready = 0.
REQ-016 WRITE: it SHALL hold all outputs stable while waitrequest = 1, with no cycle limit.
REQ-017 WRITE with waitrequest = 0: if captured last = 1, the SHALL go to IDLE, set last_owner = owner and clear the lock; otherwise it SHALL go to HOLD.
REQ-018 HOLD: req_ready[owner] = 1 and all other req_ready = 0; a valid beat from the owner SHALL be captured and the FSM SHALL go to WRITE on the same edge.
REQ-019 HOLD: each cycle without owner valid SHALL increment a 16-bit stall counter; at count = HOLD_TIMEOUT the SHALL go to IDLE, set last_owner = owner and drop the lock (timeout release).
REQ-020 The stall counter SHALL clear on every entry to HOLD and on every accepted beat.
REQ-021 Outside WRITE: chipselect = write = 0, address = 0, writedata = 0x00.
REQ-022 byteenable SHALL be 1 and read SHALL be 0 at all times.
REQ-023 Minimum spacing SHALL be 2 cycles per beat (accept edge, then one WRITE cycle with waitrequest = 0).
REQ-024 Beats from non-owners SHALL never reach the bus while a lock is held, even if their req_last = 1.
REQ-025 A non-owner's req_valid SHALL be allowed to stay high indefinitely with no effect until the lock is released.
REQ-026 An owner dropping req_valid in HOLD SHALL NOT release the lock before the timeout.
REQ-027 grant_id SHALL equal owner in WRITE and HOLD, and 0 in IDLE; busy SHALL be 1 in WRITE and HOLD.

Reset
REQ-028 On reset = 0, asynchronously: state = IDLE, owner = 0, last_owner = N_REQ-1 (so requester 0 wins first), stall counter = 0, captured beat = 0.
REQ-029 During reset, all outputs SHALL be 0 except byteenable = 1.
REQ-030 Reset asserted mid-WRITE SHALL drop write/chipselect within the same cycle, with no wait on waitrequest; the in-flight beat is discarded.
REQ-031 Reset deassertion SHALL be sampled synchronously; the first arbitration occurs on the first edge with reset = 1.

Verification
REQ-032 Req0 sends 0x001 (last=1) with waitrequest = 0 -> one write cycle, address=0, writedata=0x01; back to IDLE; busy high for exactly 1 cycle.
REQ-033 Req0 and req1 both continuously valid with single-beat messages -> bus grants alternate 0,1,0,1; no requester is granted twice in a row.
REQ-034 Req1 sends a 3-beat message 0x144,0x169,0x172 (last on the third) while req0 is valid throughout -> bus shows 0x44,0x69,0x72 with address=1, then req0 is granted.
REQ-035 waitrequest held at 1 for 5 cycles in WRITE -> address, writedata and write stay constant for 6 cycles; exactly one beat is consumed.
REQ-036 Owner stalls in HOLD with HOLD_TIMEOUT=4 -> release to IDLE after 4 idle cycles; a pending req2 is granted on the next edge.
REQ-037 reset pulsed low mid-WRITE with waitrequest = 1 -> write = 0 immediately; after release, requester 0 wins first.
